// File: rtl/icache_pkg.sv
// Shared types and address/word helpers for the direct-mapped instruction cache.
// Helper widths follow the default cache geometry.
package icache_pkg;

    localparam int FETCH_ADDR_W      = 8;
    localparam int FETCH_INDEX_W     = 2;
    localparam int FETCH_WORD_W      = 16;
    localparam int OFFSET_W          = 2;
    localparam int WORDS_PER_LINE    = 4;
    localparam int FETCH_LINE_W      = WORDS_PER_LINE * FETCH_WORD_W;
    localparam int FETCH_TAG_W       = FETCH_ADDR_W - FETCH_INDEX_W - OFFSET_W;
    localparam int FETCH_LINE_ADDR_W = FETCH_ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESPOND   = 2'd3
    } state_e;

    function automatic logic [FETCH_TAG_W-1:0] addr_tag(input logic [FETCH_ADDR_W-1:0] a);
        return a[FETCH_ADDR_W-1:FETCH_INDEX_W+OFFSET_W];
    endfunction

    function automatic logic [FETCH_INDEX_W-1:0] addr_index(input logic [FETCH_ADDR_W-1:0] a);
        return a[FETCH_INDEX_W+OFFSET_W-1:OFFSET_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [FETCH_ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    function automatic logic [FETCH_LINE_ADDR_W-1:0] addr_line(input logic [FETCH_ADDR_W-1:0] a);
        return a[FETCH_ADDR_W-1:OFFSET_W];
    endfunction

    // Offset 0 is the most significant word of the line.
    function automatic logic [FETCH_WORD_W-1:0] word_select(input logic [FETCH_LINE_W-1:0] line,
                                                           input logic [OFFSET_W-1:0]     off);
        logic [FETCH_WORD_W-1:0] w;
        w = {FETCH_WORD_W{1'b0}};
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (off == i[OFFSET_W-1:0]) begin
                w = line[(WORDS_PER_LINE-1-i)*FETCH_WORD_W +: FETCH_WORD_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/icache_sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module icache_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Count register, held once it reaches all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache in front of a line ROM with one registered cycle of latency.
// Hits answer on the next edge; misses fetch one line and answer three edges after the request.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int ADDR_W     = FETCH_ADDR_W,
    parameter int INDEX_W    = FETCH_INDEX_W,
    parameter int WORD_W     = FETCH_WORD_W,
    parameter int LINE_W     = FETCH_LINE_W,
    parameter int MEM_ADDR_W = FETCH_LINE_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  flush,
    output logic                  cpu_ready,
    output logic [WORD_W-1:0]     cpu_data,
    output logic                  cpu_busy,
    output logic                  mem_enable,
    output logic [MEM_ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0]     mem_data,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_e                state_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [LINE_W-1:0]     data_q [LINES];
    logic [ADDR_W-1:0]     addr_q;
    logic                  cpu_ready_q;
    logic                  cpu_busy_q;
    logic                  mem_enable_q;
    logic [WORD_W-1:0]     cpu_data_q;
    logic [MEM_ADDR_W-1:0] mem_address_q;

    logic [INDEX_W-1:0]    req_index_s;
    logic [INDEX_W-1:0]    miss_index_s;
    logic                  accept_s;
    logic                  hit_s;
    logic                  hit_inc_s;
    logic                  miss_inc_s;

    // Lookup of the presented address; flush takes priority over a request.
    always_comb begin
        req_index_s  = addr_index(cpu_addr);
        miss_index_s = addr_index(addr_q);
        accept_s     = (state_q == IDLE) && !flush && cpu_req;
        hit_s        = valid_q[req_index_s] && (tag_q[req_index_s] == addr_tag(cpu_addr));
        hit_inc_s    = accept_s && hit_s;
        miss_inc_s   = accept_s && !hit_s;
    end

    // Control FSM with valid bits and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            valid_q       <= {LINES{1'b0}};
            addr_q        <= {ADDR_W{1'b0}};
            cpu_ready_q   <= 1'b0;
            cpu_busy_q    <= 1'b0;
            mem_enable_q  <= 1'b0;
            cpu_data_q    <= {WORD_W{1'b0}};
            mem_address_q <= {MEM_ADDR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    cpu_ready_q <= 1'b0;
                    if (flush) begin
                        valid_q <= {LINES{1'b0}};
                    end else if (cpu_req) begin
                        if (hit_s) begin
                            cpu_ready_q <= 1'b1;
                            cpu_data_q  <= word_select(data_q[req_index_s], addr_offset(cpu_addr));
                        end else begin
                            addr_q        <= cpu_addr;
                            cpu_busy_q    <= 1'b1;
                            mem_enable_q  <= 1'b1;
                            mem_address_q <= addr_line(cpu_addr);
                            state_q       <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    mem_enable_q <= 1'b0;
                    state_q      <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    valid_q[miss_index_s] <= 1'b1;
                    cpu_ready_q           <= 1'b1;
                    cpu_data_q            <= word_select(mem_data, addr_offset(addr_q));
                    state_q               <= RESPOND;
                end
                RESPOND: begin
                    cpu_ready_q <= 1'b0;
                    cpu_busy_q  <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    cpu_ready_q  <= 1'b0;
                    cpu_busy_q   <= 1'b0;
                    mem_enable_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage need no reset; valid bits guard them.
    always_ff @(posedge clock) begin
        if (state_q == MISS_WAIT) begin
            tag_q[miss_index_s]  <= addr_tag(addr_q);
            data_q[miss_index_s] <= mem_data;
        end
    end

    icache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (hit_inc_s),
        .count_o (hit_count)
    );

    icache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (miss_inc_s),
        .count_o (miss_count)
    );

    assign cpu_ready   = cpu_ready_q;
    assign cpu_data    = cpu_data_q;
    assign cpu_busy    = cpu_busy_q;
    assign mem_enable  = mem_enable_q;
    assign mem_address = mem_address_q;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: expected words and latencies are queued
// at request time and compared when cpu_ready pulses; narrow counters exercise saturation.
module tb_icache_direct_mapped;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             cpu_req;
    logic [7:0]       cpu_addr;
    logic             flush;
    logic             cpu_ready;
    logic [15:0]      cpu_data;
    logic             cpu_busy;
    logic             mem_enable;
    logic [5:0]       mem_address;
    logic [63:0]      mem_data;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    logic [63:0] rom [64];
    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          mem_hi      = 0;
    logic [5:0]  last_mem_addr = 6'd0;
    logic [15:0] last_data     = 16'h0;
    int          exp_hits   = 0;
    int          exp_misses = 0;
    int          m0;

    icache_direct_mapped #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .flush       (flush),
        .cpu_ready   (cpu_ready),
        .cpu_data    (cpu_data),
        .cpu_busy    (cpu_busy),
        .mem_enable  (mem_enable),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Line ROM with one registered cycle of latency.
    always @(posedge clock) begin
        if (mem_enable) mem_data <= rom[mem_address];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every cpu_ready pulse.
    always @(negedge clock) begin
        if (reset) last_data <= 16'h0;
        if (mem_enable) begin
            mem_hi        <= mem_hi + 1;
            last_mem_addr <= mem_address;
        end
        if (cpu_ready) begin
            check_eq("ready_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check_eq("cpu_data", cpu_data, exp_q[0].data);
                check_eq("latency", cyc - exp_q[0].cyc, exp_q[0].lat);
                last_data <= exp_q[0].data;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_req(input logic [7:0] a, input bit hit, input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.lat  = hit ? 1 : 3;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (hit) exp_hits   = (exp_hits   < CNT_MAX) ? exp_hits + 1   : exp_hits;
        else     exp_misses = (exp_misses < CNT_MAX) ? exp_misses + 1 : exp_misses;
        cpu_req  = 1'b1;
        cpu_addr = a;
    endtask

    task automatic fetch(input logic [7:0] a, input bit hit, input logic [15:0] d);
        @(negedge clock);
        push_req(a, hit, d);
        @(negedge clock);
        cpu_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || cpu_busy) && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check_eq(tag, exp_q.size(), 0);
        check_eq("hit_count", hit_count, exp_hits);
        check_eq("miss_count", miss_count, exp_misses);
        check_eq("data_hold", cpu_data, last_data);
    endtask

    task automatic check_mem(input string tag, input int pulses, input logic [5:0] addr);
        check_eq(tag, mem_hi - m0, pulses);
        if (pulses != 0) check_eq("mem_address", last_mem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 8'h00;
        flush    = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = {4{8'(i), 8'h5a}};
        rom[0] = 64'haaaa_bbbb_cccc_dddd;
        rom[1] = 64'heeee_ffff_9999_8888;
        rom[3] = 64'h3333_4444_5555_6666;
        rom[4] = 64'h1234_5678_9abc_def0;
        rom[8] = 64'h0808_1818_2828_3838;

        repeat (2) @(negedge clock);
        check_eq("rst_ready", cpu_ready, 1'b0);
        check_eq("rst_data", cpu_data, 16'h0);
        check_eq("rst_busy", cpu_busy, 1'b0);
        check_eq("rst_mem_en", mem_enable, 1'b0);
        check_eq("rst_mem_addr", mem_address, 6'd0);
        check_eq("rst_hits", hit_count, 4'd0);
        check_eq("rst_misses", miss_count, 4'd0);
        @(negedge clock);
        reset = 1'b0;

        // Cold miss on line 0.
        m0 = mem_hi;
        fetch(8'h00, 1'b0, 16'haaaa);
        drain("cold_drain");
        check_mem("cold_mem_pulses", 1, 6'd0);

        // Back-to-back hits within line 0.
        m0 = mem_hi;
        @(negedge clock); push_req(8'h01, 1'b1, 16'hbbbb);
        @(negedge clock); push_req(8'h02, 1'b1, 16'hcccc);
        @(negedge clock); push_req(8'h03, 1'b1, 16'hdddd);
        @(negedge clock); cpu_req = 1'b0;
        drain("b2b_drain");
        check_mem("b2b_mem_pulses", 0, 6'd0);

        // Second line, then conflict eviction of line 0 by line 4.
        m0 = mem_hi;
        fetch(8'h07, 1'b0, 16'h8888);
        drain("line1_drain");
        check_mem("line1_mem_pulses", 1, 6'd1);
        m0 = mem_hi;
        fetch(8'h10, 1'b0, 16'h1234);
        drain("conflict_drain");
        check_mem("conflict_mem_pulses", 1, 6'd4);
        m0 = mem_hi;
        fetch(8'h00, 1'b0, 16'haaaa);
        drain("evicted_drain");
        check_mem("evicted_mem_pulses", 1, 6'd0);

        // Flush wins over a simultaneous request; the next access misses.
        m0 = mem_hi;
        @(negedge clock); flush = 1'b1; cpu_req = 1'b1; cpu_addr = 8'h00;
        @(negedge clock); flush = 1'b0; cpu_req = 1'b0;
        repeat (3) @(negedge clock);
        check_mem("flush_mem_pulses", 0, 6'd0);
        fetch(8'h00, 1'b0, 16'haaaa);
        drain("flush_drain");
        check_mem("flush_refill_pulses", 1, 6'd0);

        // Requests presented while busy are ignored.
        m0 = mem_hi;
        @(negedge clock); push_req(8'h0c, 1'b0, 16'h3333);
        @(negedge clock); cpu_addr = 8'h00; cpu_req = 1'b1;
        @(negedge clock); cpu_req = 1'b0;
        drain("busy_drain");
        check_mem("busy_mem_pulses", 1, 6'd3);

        // Reset during MISS_WAIT aborts the fill.
        @(negedge clock); cpu_req = 1'b1; cpu_addr = 8'h20;
        @(negedge clock); cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("abort_ready", cpu_ready, 1'b0);
        check_eq("abort_data", cpu_data, 16'h0);
        check_eq("abort_busy", cpu_busy, 1'b0);
        check_eq("abort_mem_en", mem_enable, 1'b0);
        check_eq("abort_mem_addr", mem_address, 6'd0);
        check_eq("abort_misses", miss_count, 4'd0);
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clock);
        reset = 1'b0;
        m0 = mem_hi;
        fetch(8'h20, 1'b0, 16'h0808);
        drain("after_abort_drain");
        check_mem("after_abort_pulses", 1, 6'd8);

        // Hit counter saturates and holds.
        for (int i = 0; i < 20; i++) fetch(8'h20, 1'b1, 16'h0808);
        drain("sat_drain");
        check_eq("hit_saturated", hit_count, 4'hf);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
